// File: rtl/gpr_file_mp_if.sv
// Register-file access bundle: decode read/pending lookup, writeback
// ports, scoreboard set and init control.
interface gpr_file_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          init_req;
    logic          init_busy;
    logic          we0;
    logic [AW-1:0] rw0;
    logic [DW-1:0] busW0;
    logic          we1;
    logic [AW-1:0] rw1;
    logic [DW-1:0] busW1;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;
    logic          pend_set;
    logic [AW-1:0] pend_idx;
    logic          rs_pend;
    logic          rt_pend;

    // Pipeline side: drives indices, write data and control.
    modport master (
        output init_req, we0, rw0, busW0, we1, rw1, busW1, rs, rt,
               pend_set, pend_idx,
        input  init_busy, busA, busB, rs_pend, rt_pend
    );

    // Register file side.
    modport slave (
        input  init_req, we0, rw0, busW0, we1, rw1, busW1, rs, rt,
               pend_set, pend_idx,
        output init_busy, busA, busB, rs_pend, rt_pend
    );
endinterface

// File: rtl/gpr_file_mp.sv
// Two-write / two-read general-purpose register file with a hardware
// init sweep, optional write-to-read bypass and a per-register pending
// scoreboard. The storage array has no reset so it can map to RAM.
module gpr_file_mp #(
    parameter int          DW      = 32,
    parameter int          NREG    = 32,
    parameter int          AW      = 5,
    parameter int          GP_IDX  = 28,
    parameter logic [DW-1:0] GP_INIT = 32'h1800,
    parameter int          SP_IDX  = 29,
    parameter logic [DW-1:0] SP_INIT = 32'h2ffc,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               clr,
    gpr_file_mp_if.slave       bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW:0] LAST = (AW+1)'(NREG - 1);

    state_t          state;
    logic [AW:0]     cnt;
    logic [NREG-1:0] pending;
    logic [DW-1:0]   mem [NREG];

    logic            run_ok;
    logic            wr0, wr1;
    logic [DW-1:0]   sweep_val;
    logic [NREG-1:0] set_vec, clr_vec;

    // Decode which requests actually take effect this cycle.
    always_comb begin
        run_ok    = (state == RUN) && !bus.init_req;
        wr0       = run_ok && bus.we0 && (bus.rw0 != '0);
        wr1       = run_ok && bus.we1 && (bus.rw1 != '0);
        sweep_val = '0;
        if (cnt == (AW+1)'(GP_IDX))      sweep_val = GP_INIT;
        else if (cnt == (AW+1)'(SP_IDX)) sweep_val = SP_INIT;
        set_vec = '0;
        clr_vec = '0;
        if (run_ok && bus.pend_set) set_vec[bus.pend_idx] = 1'b1;
        if (wr0)                    clr_vec[bus.rw0]      = 1'b1;
        if (wr1)                    clr_vec[bus.rw1]      = 1'b1;
        set_vec[0] = 1'b0;
    end

    // Control FSM: sweep counter, init_busy and soft re-init.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state         <= INIT;
            cnt           <= '0;
            bus.init_busy <= 1'b1;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state         <= RUN;
                bus.init_busy <= 1'b0;
            end
        end else if (bus.init_req) begin
            state         <= INIT;
            cnt           <= '0;
            bus.init_busy <= 1'b1;
        end
    end

    // Scoreboard: a new producer (set) supersedes a same-cycle writeback.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pending <= '0;
        end else if (state == RUN && bus.init_req) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    // Storage: sweep writes while initialising, else the two write ports.
    // Port 1 is assigned last so the load return wins a same-index clash.
    always_ff @(posedge clk) begin
        if (clr) begin
            if (state == INIT) begin
                mem[cnt[AW-1:0]] <= sweep_val;
            end else begin
                if (wr0) mem[bus.rw0] <= bus.busW0;
                if (wr1) mem[bus.rw1] <= bus.busW1;
            end
        end
    end

    // Read ports with optional same-cycle forwarding; reg 0 is hardwired.
    always_comb begin
        bus.busA    = '0;
        bus.busB    = '0;
        bus.rs_pend = 1'b0;
        bus.rt_pend = 1'b0;
        if (state == RUN) begin
            if (bus.rs != '0) begin
                if (BYPASS && bus.we1 && bus.rw1 == bus.rs)      bus.busA = bus.busW1;
                else if (BYPASS && bus.we0 && bus.rw0 == bus.rs) bus.busA = bus.busW0;
                else                                             bus.busA = mem[bus.rs];
            end
            if (bus.rt != '0) begin
                if (BYPASS && bus.we1 && bus.rw1 == bus.rt)      bus.busB = bus.busW1;
                else if (BYPASS && bus.we0 && bus.rw0 == bus.rt) bus.busB = bus.busW0;
                else                                             bus.busB = mem[bus.rt];
            end
            bus.rs_pend = pending[bus.rs];
            bus.rt_pend = pending[bus.rt];
        end
    end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: one bypassing instance (a) and one
// non-bypassing instance (b) share identical stimulus.
module tb_gpr_file_mp;
    logic clk;
    logic clr;
    int   n_run  = 0;
    int   n_fail = 0;

    gpr_file_mp_if #(.DW(32), .AW(5)) ifa ();
    gpr_file_mp_if #(.DW(32), .AW(5)) ifb ();

    gpr_file_mp #(.BYPASS(1'b1)) dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));
    gpr_file_mp #(.BYPASS(1'b0)) dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));

    // Mirror all inputs of instance a onto instance b.
    assign ifb.init_req = ifa.init_req;
    assign ifb.we0      = ifa.we0;
    assign ifb.rw0      = ifa.rw0;
    assign ifb.busW0    = ifa.busW0;
    assign ifb.we1      = ifa.we1;
    assign ifb.rw1      = ifa.rw1;
    assign ifb.busW1    = ifa.busW1;
    assign ifb.rs       = ifa.rs;
    assign ifb.rt       = ifa.rt;
    assign ifb.pend_set = ifa.pend_set;
    assign ifb.pend_idx = ifa.pend_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.init_req = 0; ifa.we0 = 0; ifa.rw0 = 0; ifa.busW0 = 0;
        ifa.we1 = 0; ifa.rw1 = 0; ifa.busW1 = 0; ifa.rs = 0; ifa.rt = 0;
        ifa.pend_set = 0; ifa.pend_idx = 0;
    endtask

    // Count edges until init_busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (ifa.init_busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        idle();
        clr = 0;
        ifa.rs = 28; ifa.rt = 29;
        #12;
        n_run++;
        if (ifa.init_busy !== 1'b1 || ifa.busA !== 32'h0 || ifa.busB !== 32'h0 ||
            ifa.rs_pend !== 1'b0 || ifa.rt_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b busA=%h busB=%h rsp=%b rtp=%b want 1/0/0/0/0",
                     ifa.init_busy, ifa.busA, ifa.busB, ifa.rs_pend, ifa.rt_pend);
        end
    endtask

    task automatic test_power_on_sweep();
        int n;
        logic [31:0] exp;
        @(negedge clk);
        clr = 1;
        count_busy(n);
        n_run++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL sweep_len: busy edges=%0d want 32", n);
        end
        ifa.rs = 28; ifa.rt = 29;
        #1;
        n_run++;
        if (ifa.busA !== 32'h1800 || ifa.busB !== 32'h2ffc) begin
            n_fail++;
            $display("FAIL gp_sp_init: busA=%h busB=%h want 00001800/00002ffc", ifa.busA, ifa.busB);
        end
        for (int i = 0; i < 32; i++) begin
            ifa.rs = 5'(i); ifa.rt = 5'(31 - i);
            #1;
            exp = (i == 28) ? 32'h1800 : (i == 29) ? 32'h2ffc : 32'h0;
            n_run++;
            if (ifa.busA !== exp || ifb.busA !== exp) begin
                n_fail++;
                $display("FAIL sweep_val[%0d]: a=%h b=%h want %h", i, ifa.busA, ifb.busA, exp);
            end
        end
    endtask

    task automatic test_collision();
        ifa.we0 = 1; ifa.rw0 = 5; ifa.busW0 = 32'hAAAA0000;
        ifa.we1 = 1; ifa.rw1 = 5; ifa.busW1 = 32'h5555FFFF;
        ifa.rs = 5;
        #1;
        n_run++;
        if (ifa.busA !== 32'h5555FFFF || ifb.busA !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_bypass: a=%h b=%h want 5555ffff/00000000", ifa.busA, ifb.busA);
        end
        tick();
        idle();
        ifa.rs = 5; ifa.rt = 5;
        #1;
        n_run++;
        if (ifa.busA !== 32'h5555FFFF || ifb.busB !== 32'h5555FFFF) begin
            n_fail++;
            $display("FAIL collision_store: a=%h b=%h want 5555ffff", ifa.busA, ifb.busB);
        end
    endtask

    task automatic test_bypass_reg0();
        ifa.we0 = 1; ifa.rw0 = 7; ifa.busW0 = 32'h12345678;
        ifa.rs = 7; ifa.rt = 7;
        #1;
        n_run++;
        if (ifa.busA !== 32'h12345678 || ifa.busB !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_on: busA=%h busB=%h want 12345678", ifa.busA, ifa.busB);
        end
        n_run++;
        if (ifb.busA !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_off: busA=%h want 00000000", ifb.busA);
        end
        tick();
        idle();
        ifa.rs = 7;
        #1;
        n_run++;
        if (ifb.busA !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_off_stored: busA=%h want 12345678", ifb.busA);
        end
        ifa.we0 = 1; ifa.rw0 = 0; ifa.busW0 = 32'hFFFFFFFF;
        ifa.we1 = 1; ifa.rw1 = 0; ifa.busW1 = 32'hFFFFFFFF;
        ifa.rs = 0; ifa.rt = 0;
        #1;
        n_run++;
        if (ifa.busA !== 32'h0 || ifa.busB !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_same_cycle: busA=%h busB=%h want 0", ifa.busA, ifa.busB);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (ifa.busA !== 32'h0 || ifb.busA !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_after: a=%h b=%h want 0", ifa.busA, ifb.busA);
        end
    endtask

    task automatic test_scoreboard();
        ifa.pend_set = 1; ifa.pend_idx = 9; ifa.rs = 9; ifa.rt = 9;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_same_cycle: rs_pend=%b want 0", ifa.rs_pend);
        end
        tick();
        ifa.pend_set = 0;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b1 || ifa.rt_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: rs_pend=%b rt_pend=%b want 1/1", ifa.rs_pend, ifa.rt_pend);
        end
        ifa.we1 = 1; ifa.rw1 = 9; ifa.busW1 = 32'h99;
        ifa.pend_set = 1; ifa.pend_idx = 9;
        tick();
        idle();
        ifa.rs = 9;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set_wins: rs_pend=%b want 1", ifa.rs_pend);
        end
        ifa.we0 = 1; ifa.rw0 = 9; ifa.busW0 = 32'h77;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_no_bypass: rs_pend=%b want 1", ifa.rs_pend);
        end
        tick();
        idle();
        ifa.rs = 9;
        ifa.pend_set = 1; ifa.pend_idx = 0;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_clear: rs_pend=%b want 0", ifa.rs_pend);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_idx0: rs_pend=%b want 0", ifa.rs_pend);
        end
    endtask

    task automatic test_soft_reinit();
        int n;
        ifa.we0 = 1; ifa.rw0 = 3; ifa.busW0 = 32'hDEAD;
        ifa.pend_set = 1; ifa.pend_idx = 12;
        tick();
        idle();
        ifa.rs = 3; ifa.rt = 12;
        #1;
        n_run++;
        if (ifa.busA !== 32'hDEAD || ifa.rt_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reinit: busA=%h rt_pend=%b want 0000dead/1", ifa.busA, ifa.rt_pend);
        end
        // Writes and pend_set in the init_req cycle and during the sweep are dropped.
        ifa.init_req = 1;
        ifa.we0 = 1; ifa.rw0 = 20; ifa.busW0 = 32'hBEEF;
        ifa.we1 = 1; ifa.rw1 = 3;  ifa.busW1 = 32'hCAFE;
        ifa.pend_set = 1; ifa.pend_idx = 20;
        tick();
        ifa.init_req = 0;
        count_busy(n);
        n_run++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL reinit_len: busy edges=%0d want 32", n);
        end
        idle();
        ifa.rs = 3; ifa.rt = 20;
        #1;
        n_run++;
        if (ifa.busA !== 32'h0 || ifa.busB !== 32'h0) begin
            n_fail++;
            $display("FAIL reinit_regs: busA=%h busB=%h want 0/0", ifa.busA, ifa.busB);
        end
        ifa.rs = 12;
        #1;
        n_run++;
        if (ifa.rs_pend !== 1'b0 || ifa.rt_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_pend: rs_pend=%b rt_pend=%b want 0/0", ifa.rs_pend, ifa.rt_pend);
        end
        ifa.rs = 28; ifa.rt = 29;
        #1;
        n_run++;
        if (ifa.busA !== 32'h1800 || ifa.busB !== 32'h2ffc) begin
            n_fail++;
            $display("FAIL reinit_gp_sp: busA=%h busB=%h want 00001800/00002ffc", ifa.busA, ifa.busB);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        ifa.init_req = 1;
        tick();
        ifa.init_req = 0;
        repeat (10) tick();
        clr = 0;
        #2;
        n_run++;
        if (ifa.init_busy !== 1'b1 || ifa.busA !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b busA=%h want 1/0", ifa.init_busy, ifa.busA);
        end
        clr = 1;
        count_busy(n);
        n_run++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL mid_reset_len: busy edges=%0d want 32", n);
        end
        ifa.rs = 28; ifa.rt = 7;
        #1;
        n_run++;
        if (ifa.busA !== 32'h1800 || ifa.busB !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_vals: busA=%h busB=%h want 00001800/0", ifa.busA, ifa.busB);
        end
    endtask

    initial begin
        test_reset();
        test_power_on_sweep();
        test_collision();
        test_bypass_reg0();
        test_scoreboard();
        test_soft_reinit();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
